// File: rtl/team_08_uart_tx.sv
// team_08_uart_tx: FIFO-buffered 8N1 UART transmitter for the team_08 debug link.
// Bytes strobed in on wr_en are queued in a FIFO_DEPTH-entry FIFO and sent LSB
// first, with a bit period of div+1 clocks. The divisor is latched at frame start.
// Optional macro UART_PARITY_EN adds a parity bit after the data bits. The parity
// value is ^byte ^ parity_odd, with parity_odd sampled at frame start.
// All outputs come from flops. Each output flop is loaded from the next-state
// values, so output timing lines up with the FSM state.
module team_08_uart_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          en,
  input  logic [DIV_WIDTH-1:0]          div,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          clr_ovf,
`ifdef UART_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          tx,
  output logic                          tx_oeb,
  output logic                          busy,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          done,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]        DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1'b1);
  localparam logic [AW-1:0]        PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]        PTR_ONE  = AW'(1'b1);
  localparam logic [DIV_WIDTH-1:0] TMR_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] TMR_ONE  = DIV_WIDTH'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } state_t;

`ifdef UART_PARITY_EN
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
`endif

  // FIFO storage and bookkeeping
  logic [7:0]           mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]        count_r, count_nxt_s;
  logic                 push_s, drop_s, pop_s, ovf_r, ovf_nxt_s;
  logic                 empty_r, full_r;

  // Frame engine
  state_t               state_r, state_nxt_s;
  logic [DIV_WIDTH-1:0] timer_r, timer_nxt_s, div_q_r, div_q_nxt_s;
  logic [2:0]           bit_idx_r, bit_idx_nxt_s;
  logic [7:0]           shift_r, shift_nxt_s;
  logic                 load_s, fifo_has_s, timer_zero_s;
  logic                 tx_r, tx_nxt_s, busy_r, busy_nxt_s, done_r, done_nxt_s, oeb_r;
`ifdef UART_PARITY_EN
  logic                 par_bit_r, par_bit_nxt_s;
`endif

  assign fifo_has_s   = (count_r != CNT_ZERO);
  assign timer_zero_s = (timer_r == TMR_ZERO);

  // FIFO accept/drop decision, next count and sticky overflow
  always_comb begin
    push_s      = 1'b0;
    drop_s      = 1'b0;
    count_nxt_s = count_r;
    ovf_nxt_s   = ovf_r;
    if (wr_en) begin
      if ((count_r < DEPTH_C) || pop_s) begin
        push_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
    // A dropped write wins over a clear in the same cycle.
    if (drop_s) begin
      ovf_nxt_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // FIFO memory, pointers, count and flags
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ovf_r    <= 1'b0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      empty_r <= (count_nxt_s == CNT_ZERO);
      full_r  <= (count_nxt_s == DEPTH_C);
    end
  end

  // Frame sequencer: next state, bit timer, shifter and derived output values
  always_comb begin
    state_nxt_s   = state_r;
    timer_nxt_s   = timer_r;
    div_q_nxt_s   = div_q_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    load_s        = 1'b0;
    pop_s         = 1'b0;
`ifdef UART_PARITY_EN
    par_bit_nxt_s = par_bit_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (en && fifo_has_s) begin
          load_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_zero_s) begin
          state_nxt_s   = ST_DATA;
          timer_nxt_s   = div_q_r;
          bit_idx_nxt_s = 3'd0;
        end else begin
          timer_nxt_s = timer_r - TMR_ONE;
        end
      end
      ST_DATA: begin
        if (timer_zero_s) begin
          timer_nxt_s = div_q_r;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            state_nxt_s = ST_STOP;
`endif
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
            shift_nxt_s   = {1'b0, shift_r[7:1]};
          end
        end else begin
          timer_nxt_s = timer_r - TMR_ONE;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (timer_zero_s) begin
          state_nxt_s = ST_STOP;
          timer_nxt_s = div_q_r;
        end else begin
          timer_nxt_s = timer_r - TMR_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (timer_zero_s) begin
          if (en && fifo_has_s) begin
            load_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          timer_nxt_s = timer_r - TMR_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    // Starting a frame pops the head and latches the divisor, from IDLE or
    // straight out of STOP.
    if (load_s) begin
      pop_s       = 1'b1;
      shift_nxt_s = mem_r[rd_ptr_r];
      div_q_nxt_s = div;
      timer_nxt_s = div;
      state_nxt_s = ST_START;
`ifdef UART_PARITY_EN
      par_bit_nxt_s = calc_parity(mem_r[rd_ptr_r], parity_odd);
`endif
    end else begin
      pop_s = 1'b0;
    end
    case (state_nxt_s)
      ST_IDLE:   tx_nxt_s = 1'b1;
      ST_START:  tx_nxt_s = 1'b0;
      ST_DATA:   tx_nxt_s = shift_nxt_s[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx_nxt_s = par_bit_nxt_s;
`endif
      ST_STOP:   tx_nxt_s = 1'b1;
      default:   tx_nxt_s = 1'b1;
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_STOP) && (timer_nxt_s == TMR_ZERO);
  end

  // Frame sequencer state and registered line/status outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r   <= ST_IDLE;
      timer_r   <= TMR_ZERO;
      div_q_r   <= TMR_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      oeb_r     <= 1'b1;
`ifdef UART_PARITY_EN
      par_bit_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      timer_r   <= timer_nxt_s;
      div_q_r   <= div_q_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      tx_r      <= tx_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      oeb_r     <= ~en;
`ifdef UART_PARITY_EN
      par_bit_r <= par_bit_nxt_s;
`endif
    end
  end

  assign tx         = tx_r;
  assign tx_oeb     = oeb_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign fifo_empty = empty_r;
  assign fifo_full  = full_r;
  assign fifo_count = count_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_team_08_uart_tx.sv
// Testbench for team_08_uart_tx. A UART receiver model decodes tx and checks
// every decoded byte against a scoreboard queue that is filled as bytes are written.
module tb_team_08_uart_tx;

  localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        nrst, en, wr_en, clr_ovf;
  logic [15:0] div;
  logic [7:0]  wr_data;
`ifdef UART_PARITY_EN
  logic        parity_odd;
`endif
  logic        tx, tx_oeb, busy, fifo_empty, fifo_full, done, overflow;
  logic [3:0]  fifo_count;

  team_08_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
    .clk(clk), .nrst(nrst), .en(en), .div(div), .wr_en(wr_en), .wr_data(wr_data),
    .clr_ovf(clr_ovf),
`ifdef UART_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx(tx), .tx_oeb(tx_oeb), .busy(busy), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_par_q[$];
  int         start_q[$];
  int         done_q[$];
  logic       mon_en = 1'b0;
  int         cur_div = 0;
  logic       last_par = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [7:0] b);
    exp_q.push_back(b);
`ifdef UART_PARITY_EN
    exp_par_q.push_back((^b) ^ parity_odd);
`endif
  endtask

  // Drive one write strobe (optionally with clr_ovf) for one cycle.
  task automatic send(input logic [7:0] b, input logic expect_it, input logic clr);
    wr_en = 1'b1; wr_data = b; clr_ovf = clr;
    if (expect_it) sb_push(b);
    @(negedge clk);
    wr_en = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val({"drain_", tag}, 32'(n < 3000), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_tx"},       32'(tx),         32'd1);
    check_val({tag, "_tx_oeb"},   32'(tx_oeb),     32'd1);
    check_val({tag, "_busy"},     32'(busy),       32'd0);
    check_val({tag, "_empty"},    32'(fifo_empty), 32'd1);
    check_val({tag, "_full"},     32'(fifo_full),  32'd0);
    check_val({tag, "_count"},    32'(fifo_count), 32'd0);
    check_val({tag, "_done"},     32'(done),       32'd0);
    check_val({tag, "_overflow"}, 32'(overflow),   32'd0);
  endtask

  // UART receiver model: decodes each frame on tx and scores it.
  always begin : rx_monitor
    int d;
    int st;
    logic [7:0] b;
    logic ok;
    logic pb;
    @(negedge clk);
    if (mon_en && nrst && tx === 1'b0) begin
      d = cur_div + 1;
      st = cyc;
      ok = 1'b1;
      for (int i = 1; i < d; i++) begin
        @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
      end
      check_val("start_bit", 32'(ok), 32'd1);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        b[k] = tx;
        ok = 1'b1;
        for (int i = 1; i < d; i++) begin
          @(negedge clk);
          if (tx !== b[k]) ok = 1'b0;
        end
        check_val("data_bit_stable", 32'(ok), 32'd1);
      end
`ifdef UART_PARITY_EN
      @(negedge clk);
      pb = tx;
      ok = 1'b1;
      for (int i = 1; i < d; i++) begin
        @(negedge clk);
        if (tx !== pb) ok = 1'b0;
      end
      check_val("parity_stable", 32'(ok), 32'd1);
      last_par = pb;
      if (exp_par_q.size() != 0) check_val("parity_bit", 32'(pb), 32'(exp_par_q.pop_front()));
      else check_val("parity_unexpected", 32'd1, 32'd0);
`else
      pb = 1'b0;
`endif
      ok = 1'b1;
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        if (done !== (i == d - 1)) ok = 1'b0;
      end
      check_val("stop_and_done", 32'(ok), 32'd1);
      start_q.push_back(st);
      done_q.push_back(cyc);
      if (exp_q.size() == 0) check_val("unexpected_frame", 32'(b), 32'hFFFF_FFFF);
      else check_val("rx_byte", 32'(b), 32'(exp_q.pop_front()));
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w;
    nrst = 1'b0; en = 1'b0; div = 16'd0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
`ifdef UART_PARITY_EN
    parity_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset("rst");
    nrst = 1'b1;
    @(negedge clk);
    check_reset("post_rst");
    mon_en = 1'b1;

    // Single byte, div=3: latency, timing and done/busy edges.
    div = 16'd3; cur_div = 3; en = 1'b1;
    @(negedge clk);
    check_val("t1_oeb", 32'(tx_oeb), 32'd0);
    check_val("t1_empty_pre", 32'(fifo_empty), 32'd1);
    start_q.delete(); done_q.delete();
    w = cyc;
    send(8'hA5, 1'b1, 1'b0);
    check_val("t1_empty_n1", 32'(fifo_empty), 32'd0);
    check_val("t1_tx_n1", 32'(tx), 32'd1);
    check_val("t1_busy_n1", 32'(busy), 32'd0);
    wait_cycle(w + 2);
    check_val("t1_tx_n2", 32'(tx), 32'd0);
    check_val("t1_busy_n2", 32'(busy), 32'd1);
    wait_cycle(w + 1 + NB * 4);
    check_val("t1_done_pulse", 32'(done), 32'd1);
    check_val("t1_busy_last", 32'(busy), 32'd1);
    wait_cycle(w + 2 + NB * 4);
    check_val("t1_done_after", 32'(done), 32'd0);
    check_val("t1_busy_fall", 32'(busy), 32'd0);
    wait_idle("t1");
    check_val("t1_frames", 32'(start_q.size()), 32'd1);
    if (start_q.size() == 1) begin
      check_val("t1_start_lat", 32'(start_q[0] - w), 32'd2);
      check_val("t1_done_cyc", 32'(done_q[0] - w), 32'(1 + NB * 4));
    end

    // Overflow with en=0, drop+clear collision, then drain 0x01..0x08.
    en = 1'b0; div = 16'd1; cur_div = 1;
    @(negedge clk);
    for (int i = 1; i <= 9; i++) send(8'(i), (i <= 8), 1'b0);
    check_val("t2_full", 32'(fifo_full), 32'd1);
    check_val("t2_count", 32'(fifo_count), 32'd8);
    check_val("t2_ovf", 32'(overflow), 32'd1);
    check_val("t2_oeb", 32'(tx_oeb), 32'd1);
    check_val("t2_idle", 32'(busy), 32'd0);
    send(8'h0A, 1'b0, 1'b1);
    check_val("t2_ovf_drop_vs_clr", 32'(overflow), 32'd1);
    check_val("t2_count_hold", 32'(fifo_count), 32'd8);
    en = 1'b1;
    wait_idle("t2");
    check_val("t2_ovf_sticky", 32'(overflow), 32'd1);
    check_val("t2_drained", 32'(fifo_empty), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check_val("t2_ovf_cleared", 32'(overflow), 32'd0);

    // Back-to-back frames at div=0.
    div = 16'd0; cur_div = 0;
    @(negedge clk);
    start_q.delete(); done_q.delete();
    w = cyc;
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    wait_cycle(w + 1 + 2 * NB);
    check_val("t3_empty_before_pop3", 32'(fifo_empty), 32'd0);
    wait_cycle(w + 2 + 2 * NB);
    check_val("t3_empty_after_pop3", 32'(fifo_empty), 32'd1);
    wait_cycle(w + 1 + 3 * NB);
    check_val("t3_done_last", 32'(done), 32'd1);
    check_val("t3_busy_last", 32'(busy), 32'd1);
    wait_cycle(w + 2 + 3 * NB);
    check_val("t3_busy_fall", 32'(busy), 32'd0);
    wait_idle("t3");
    check_val("t3_frames", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      check_val("t3_start0", 32'(start_q[0] - w), 32'd2);
      check_val("t3_gap01", 32'(start_q[1] - start_q[0]), 32'(NB));
      check_val("t3_gap12", 32'(start_q[2] - start_q[1]), 32'(NB));
      check_val("t3_done_gap", 32'(done_q[2] - done_q[1]), 32'(NB));
    end

    // Push at full in the same cycle as a pop.
    en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b1, 1'b0);
    check_val("t4_full", 32'(fifo_full), 32'd1);
    en = 1'b1; wr_en = 1'b1; wr_data = 8'h18;
    sb_push(8'h18);
    @(negedge clk);
    wr_en = 1'b0;
    check_val("t4_count", 32'(fifo_count), 32'd8);
    check_val("t4_ovf", 32'(overflow), 32'd0);
    check_val("t4_full_after", 32'(fifo_full), 32'd1);
    check_val("t4_busy", 32'(busy), 32'd1);
    wait_idle("t4");

    // Disable during data bit 3, then reset in the middle of a frame.
    div = 16'd1; cur_div = 1;
    @(negedge clk);
    w = cyc;
    send(8'hC3, 1'b1, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    wait_cycle(w + 10);
    en = 1'b0;
    wait_idle("t5");
    repeat (30) @(negedge clk);
    check_val("t5_no_restart", 32'(busy), 32'd0);
    check_val("t5_retained", 32'(fifo_count), 32'd1);
    check_val("t5_tx_idle", 32'(tx), 32'd1);
    check_val("t5_oeb", 32'(tx_oeb), 32'd1);
    send(8'h5A, 1'b0, 1'b0);
    mon_en = 1'b0;
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("t5_tx_start", 32'(tx), 32'd0);
    check_val("t5_count_pre", 32'(fifo_count), 32'd1);
    #1 nrst = 1'b0;
    #1;
    check_val("t5_rst_tx", 32'(tx), 32'd1);
    check_val("t5_rst_count", 32'(fifo_count), 32'd0);
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_empty", 32'(fifo_empty), 32'd1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check_reset("t5_after");
    mon_en = 1'b1;

`ifdef UART_PARITY_EN
    // Parity bit for 0x07 with even and odd sense.
    en = 1'b1; parity_odd = 1'b0;
    @(negedge clk);
    send(8'h07, 1'b1, 1'b0);
    wait_idle("t6a");
    check_val("t6_par_even", 32'(last_par), 32'd1);
    parity_odd = 1'b1;
    @(negedge clk);
    send(8'h07, 1'b1, 1'b0);
    wait_idle("t6b");
    check_val("t6_par_odd", 32'(last_par), 32'd0);
`endif

    check_val("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/team_08_uart_tx.md
Name: team_08_uart_tx

Overview:
- Byte-serial transmitter for team_08, directly downstream of the team_08 Wishbone bus-wrapper register bank.
- Consumes byte writes strobed out of the WB data register into an internal FIFO.
- Serialises each byte as 8N1 UART onto one GPIO pad, with pad output-enable and status flags read back through the bus wrapper.
- Drives the team's off-chip debug/telemetry link.

Parameters:
FIFO_DEPTH, 8, number of byte entries in the transmit FIFO; power of 2, minimum 2
DIV_WIDTH, 16, width of the baud divisor input

Ports:
clk  input  1  system clock (wb_clk_i at wrapper level)
nrst  input  1  asynchronous active-low reset
en  input  1  transmitter enable (WB control register bit 0)
div  input  DIV_WIDTH  baud divisor; bit period = div+1 clk cycles
wr_en  input  1  one-cycle write strobe from bus wrapper
wr_data  input  8  byte to enqueue
clr_ovf  input  1  clears sticky overflow flag
tx  output  1  serial line to gpio_out
tx_oeb  output  1  active-low pad output enable to gpio_oeb
busy  output  1  frame in progress
fifo_empty  output  1  FIFO has no entries
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
fifo_count  output  $clog2(FIFO_DEPTH)+1  current entry count
done  output  1  one-cycle pulse at end of each stop bit
overflow  output  1  sticky: write dropped while full

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - tx=1, tx_oeb=1, busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, done=0, overflow=0.
  - FSM in IDLE; FIFO pointers zero.
- All outputs are registered.
- tx_oeb = registered ~en (one cycle lag).
- FIFO:
  - Write accepted iff wr_en && (count<FIFO_DEPTH || pop in same cycle).
  - Otherwise the byte is dropped, overflow is set, and count is unchanged.
  - Simultaneous push and pop: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - clr_ovf clears overflow; if clr_ovf and a dropped write occur in the same cycle, overflow stays set.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. If en && !fifo_empty: pop head into shift register, latch div into div_q, go START.
  - START: tx=0 for div_q+1 cycles, then go DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first) for div_q+1 cycles per bit; shift right; after bit 7 go STOP.
  - STOP: tx=1 for div_q+1 cycles. On the last cycle, done=1.
  - Leaving STOP: if en && !fifo_empty, pop and go directly to START (zero gap); otherwise go IDLE.
- busy=1 in START, DATA and STOP.
- Bit timer counts down from div_q to 0. div=0 gives 1 cycle per bit. A div change mid-frame takes effect only at the next frame.
- Latency: wr_en at cycle N with the FIFO empty, en=1 and FSM idle:
  - fifo_empty drops at N+1.
  - Pop at N+1.
  - tx goes low and busy rises at N+2.
- Frame length: 10*(div+1) cycles; back-to-back frames are contiguous.
- en deasserted mid-frame: the current frame completes, no new pop, FSM goes to IDLE. FIFO contents are retained.
- Reset mid-frame: tx returns to 1 immediately; the FIFO is flushed.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - Adds input port parity_odd (1 bit) and state PARITY between DATA and STOP.
  - Parity bit = ^byte ^ parity_odd, held div_q+1 cycles.
  - parity_odd is latched at frame start.
  - Frame length is 11*(div+1).
- Undefined: no port, no state, 10-bit frames.

Test Plan:
- Single byte: en=1, div=3, write 0xA5. Required response:
  - tx low from write+2 for 4 cycles.
  - Then 1,0,1,0,0,1,0,1, each 4 cycles.
  - Stop high 4 cycles.
  - done pulses at cycle write+41; busy falls the next cycle.
- Overflow: en=0, write 9 bytes 0x01..0x09. Required response:
  - fifo_full=1, fifo_count=8, overflow=1.
  - Then en=1: exactly 0x01..0x08 are transmitted.
  - clr_ovf clears overflow.
- Back-to-back: div=0, write 0x00, 0xFF, 0x55 on consecutive cycles. Required response:
  - 30 contiguous tx cycles with no idle gap.
  - done pulses 10 cycles apart; fifo_empty=1 after the third pop.
- Push at full with pop: FIFO full and the FSM pops in the same cycle as wr_en. Required response: write accepted, count stays 8, overflow=0.
- Disable/reset mid-frame: clear en during DATA bit 3. Required response:
  - The frame finishes; the next queued byte is not started.
  - Then assert nrst=0 mid-frame: tx=1 and fifo_count=0 asynchronously.
- Parity, UART_PARITY_EN defined: send 0x07. Required response:
  - parity_odd=0 gives parity bit 1.
  - parity_odd=1 gives parity bit 0.
  - Frame is 11*(div+1) cycles.
